// File: rtl/i2c_thermo_responder.sv
// I2C target that stands in for the 8-pixel IR thermopile sensor: accepts the
// command write, then serves a snapshotted PTAT + 8 pixel frame closed by a CRC-8 PEC.
`timescale 1ns/1ps
module i2c_thermo_responder #(
  parameter logic [6:0] I2C_ADDR    = 7'h0A,
  parameter logic [7:0] CMD_BYTE    = 8'h4C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        ref_clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] ptat,
  input  logic [15:0] pix_0,
  input  logic [15:0] pix_1,
  input  logic [15:0] pix_2,
  input  logic [15:0] pix_3,
  input  logic [15:0] pix_4,
  input  logic [15:0] pix_5,
  input  logic [15:0] pix_6,
  input  logic [15:0] pix_7,
  output logic        busy,
  output logic        frame_sent
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] ADDR       = 4'd1;
  localparam logic [3:0] ADDR_ACK_W = 4'd2;
  localparam logic [3:0] ADDR_ACK_R = 4'd3;
  localparam logic [3:0] CMD        = 4'd4;
  localparam logic [3:0] CMD_DONE   = 4'd5;
  localparam logic [3:0] TX_BYTE    = 4'd6;
  localparam logic [3:0] TX_ACK     = 4'd7;
  localparam logic [3:0] IGNORE     = 4'd8;

  logic [3:0]             state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic [7:0]             shift_reg;
  logic [3:0]             bit_cnt;
  logic [1:0]             ack_phase;
  logic [4:0]             byte_idx;
  logic [7:0]             crc_q;
  logic [143:0]           frame_q;
  logic                   sda_oe;
  logic                   cmd_valid;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic [7:0] rx_byte;
  logic       addr_match;
  logic [4:0] next_idx;
  logic [7:0] next_byte;

  function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign SDA = sda_oe ? 1'b0 : 1'bz;
  assign busy = (state != IDLE);

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte    = {shift_reg[6:0], sda_s};
  assign addr_match = (rx_byte[7:1] == I2C_ADDR);
  assign next_idx   = (byte_idx == 5'd19) ? 5'd19 : byte_idx + 5'd1;

  // Bytes past the PEC read as all ones so the bus is simply left released.
  always_comb begin
    next_byte = 8'hFF;
    if (next_idx < 5'd18) begin
      next_byte = frame_q[{next_idx, 3'b000} +: 8];
    end else if (next_idx == 5'd18) begin
      next_byte = crc_q;
    end
  end

  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_d      <= 1'b1;
      sda_d      <= 1'b1;
      shift_reg  <= 8'h00;
      bit_cnt    <= 4'd0;
      ack_phase  <= 2'd0;
      byte_idx   <= 5'd0;
      crc_q      <= 8'h00;
      frame_q    <= '0;
      sda_oe     <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_d      <= scl_s;
      sda_d      <= sda_s;
      frame_sent <= 1'b0;

      if (stop_cond) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        cmd_valid <= 1'b0;
        ack_phase <= 2'd0;
      end else if (start_cond) begin
        state     <= ADDR;
        bit_cnt   <= 4'd0;
        sda_oe    <= 1'b0;
        ack_phase <= 2'd0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (addr_match && !rx_byte[0]) begin
                  state     <= ADDR_ACK_W;
                  ack_phase <= 2'd1;
                end else if (addr_match && rx_byte[0] && cmd_valid) begin
                  state     <= ADDR_ACK_R;
                  ack_phase <= 2'd1;
                  frame_q   <= {pix_7, pix_6, pix_5, pix_4, pix_3, pix_2, pix_1, pix_0, ptat};
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end

          ADDR_ACK_W: begin
            if (scl_fall) begin
              if (ack_phase == 2'd1) begin
                sda_oe    <= 1'b1;
                ack_phase <= 2'd2;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 2'd0;
                bit_cnt   <= 4'd0;
                state     <= CMD;
              end
            end
          end

          // Byte 0 is loaded while the ACK is driven so its MSB can follow on the very next fall.
          ADDR_ACK_R: begin
            if (scl_fall) begin
              if (ack_phase == 2'd1) begin
                sda_oe    <= 1'b1;
                ack_phase <= 2'd2;
                shift_reg <= frame_q[7:0];
                crc_q     <= crc8_fold(8'h00, frame_q[7:0]);
                byte_idx  <= 5'd0;
              end else begin
                ack_phase <= 2'd0;
                state     <= TX_BYTE;
                sda_oe    <= ~shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_cnt   <= 4'd1;
              end
            end
          end

          CMD: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (rx_byte == CMD_BYTE) begin
                  cmd_valid <= 1'b1;
                  ack_phase <= 2'd1;
                  state     <= CMD_DONE;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end

          CMD_DONE: begin
            if (ack_phase != 2'd0) begin
              if (scl_fall) begin
                sda_oe    <= (ack_phase == 2'd1);
                ack_phase <= (ack_phase == 2'd1) ? 2'd2 : 2'd0;
              end
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                state   <= IGNORE;
              end
            end
          end

          TX_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                sda_oe    <= ~shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (byte_idx == 5'd18) begin
                frame_sent <= 1'b1;
              end
              if (!sda_s) begin
                byte_idx  <= next_idx;
                shift_reg <= next_byte;
                bit_cnt   <= 4'd0;
                state     <= TX_BYTE;
                if (next_idx < 5'd18) begin
                  crc_q <= crc8_fold(crc_q, next_byte);
                end
              end else begin
                state <= IGNORE;
              end
            end
          end

          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_thermo_responder.sv
// Bit-banged I2C master driving the thermopile responder, checked against a
// byte-level frame model with a polynomial-division PEC.
`timescale 1ns/1ps
module tb_i2c_thermo_responder;

  localparam time Q = 50;

  logic        ref_clk = 1'b0;
  logic        rst;
  logic        scl_m;
  logic        m_sda;
  wire         sda;
  logic [15:0] ptat;
  logic [15:0] pix [8];
  logic        busy;
  logic        frame_sent;

  int errors = 0;
  int checks = 0;
  int fs_cnt = 0;
  int low_cnt = 0;
  logic [7:0] rx_data [24];

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  always #5 ref_clk = ~ref_clk;

  i2c_thermo_responder dut (
    .ref_clk(ref_clk), .rst(rst), .SCL(scl_m), .SDA(sda), .ptat(ptat),
    .pix_0(pix[0]), .pix_1(pix[1]), .pix_2(pix[2]), .pix_3(pix[3]),
    .pix_4(pix[4]), .pix_5(pix[5]), .pix_6(pix[6]), .pix_7(pix[7]),
    .busy(busy), .frame_sent(frame_sent)
  );

  // Running tallies of frame_sent pulses and of cycles where the DUT holds SDA low.
  always @(posedge ref_clk) begin
    if (frame_sent) fs_cnt <= fs_cnt + 1;
    if (m_sda && sda === 1'b0) low_cnt <= low_cnt + 1;
  end

  function automatic logic [7:0] data_byte(input int idx, input logic [15:0] pt, input logic [15:0] px [8]);
    if (idx < 2) return 8'((pt >> (8 * idx)) & 16'hFF);
    return 8'((px[(idx - 2) / 2] >> (8 * (idx % 2))) & 16'hFF);
  endfunction

  // PEC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] model_pec(input logic [15:0] pt, input logic [15:0] px [8]);
    logic [8:0] rem;
    logic [7:0] b;
    rem = 9'd0;
    for (int n = 0; n < 19; n++) begin
      b = (n < 18) ? data_byte(n, pt, px) : 8'h00;
      for (int k = 7; k >= 0; k--) begin
        rem = {rem[7:0], b[k]};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  function automatic logic [7:0] exp_byte(input int idx, input logic [15:0] pt, input logic [15:0] px [8]);
    if (idx < 18) return data_byte(idx, pt, px);
    if (idx == 18) return model_pec(pt, px);
    return 8'hFF;
  endfunction

  task automatic write_bit(input logic b);
    m_sda = b;
    #Q scl_m = 1'b1;
    #(2 * Q) scl_m = 1'b0;
    #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1;
    #Q scl_m = 1'b1;
    #Q b = sda;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    #Q scl_m = 1'b1;
    #Q m_sda = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #Q scl_m = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    d = v;
    write_bit(ack ? 1'b0 : 1'b1);
  endtask

  task automatic open_read(output logic aw, output logic ac, output logic ar);
    i2c_start();
    write_byte(8'h14, aw);
    write_byte(8'h4C, ac);
    i2c_start();
    write_byte(8'h15, ar);
  endtask

  task automatic read_frame(input int n);
    for (int i = 0; i < n; i++) read_byte(i != n - 1, rx_data[i]);
  endtask

  task automatic randomize_inputs();
    ptat = 16'($urandom);
    for (int k = 0; k < 8; k++) pix[k] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0; scl_m = 1'b1; m_sda = 1'b1; ptat = 16'h0;
    for (int k = 0; k < 8; k++) pix[k] = 16'h0;
    repeat (5) @(posedge ref_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_sent !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_sent: got %b expected 0", frame_sent); end
    checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected released", sda); end
    rst = 1'b1;
    repeat (5) @(posedge ref_clk);
  endtask

  task automatic test_zero_frame();
    logic aw, ac, ar;
    int fs0;
    fs0 = fs_cnt;
    open_read(aw, ac, ar);
    read_frame(19);
    i2c_stop();
    checks++; if (aw !== 1'b1) begin errors++; $display("[TB] FAIL zero_addr_w_ack: got %b expected 1", aw); end
    checks++; if (ac !== 1'b1) begin errors++; $display("[TB] FAIL zero_cmd_ack: got %b expected 1", ac); end
    checks++; if (ar !== 1'b1) begin errors++; $display("[TB] FAIL zero_addr_r_ack: got %b expected 1", ar); end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (rx_data[i] !== 8'h00) begin errors++; $display("[TB] FAIL zero_byte%0d: got %h expected 00", i, rx_data[i]); end
    end
    checks++; if (fs_cnt - fs0 != 1) begin errors++; $display("[TB] FAIL zero_frame_sent: got %0d pulses expected 1", fs_cnt - fs0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_ordering();
    logic aw, ac, ar;
    logic [7:0] e;
    randomize_inputs();
    ptat = 16'h0123; pix[0] = 16'h0A0B; pix[7] = 16'hBEEF;
    open_read(aw, ac, ar);
    read_frame(19);
    i2c_stop();
    checks++; if ({aw, ac, ar} !== 3'b111) begin errors++; $display("[TB] FAIL order_acks: got %b expected 111", {aw, ac, ar}); end
    for (int i = 0; i < 19; i++) begin
      e = exp_byte(i, ptat, pix);
      checks++;
      if (rx_data[i] !== e) begin errors++; $display("[TB] FAIL order_byte%0d: got %h expected %h", i, rx_data[i], e); end
    end
  endtask

  task automatic test_random_frames();
    logic aw, ac, ar;
    logic [7:0] e;
    for (int t = 0; t < 2; t++) begin
      randomize_inputs();
      open_read(aw, ac, ar);
      read_frame(19);
      for (int i = 0; i < 19; i++) begin
        e = exp_byte(i, ptat, pix);
        checks++;
        if (rx_data[i] !== e) begin errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", t, i, rx_data[i], e); end
      end
      // A repeated START keeps the command, so a second read needs no new write.
      randomize_inputs();
      i2c_start();
      write_byte(8'h15, ar);
      checks++; if (ar !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_sr_ack: got %b expected 1", t, ar); end
      read_frame(19);
      i2c_stop();
      for (int i = 0; i < 19; i++) begin
        e = exp_byte(i, ptat, pix);
        checks++;
        if (rx_data[i] !== e) begin errors++; $display("[TB] FAIL rand%0d_sr_byte%0d: got %h expected %h", t, i, rx_data[i], e); end
      end
    end
  endtask

  task automatic test_snapshot();
    logic aw, ac, ar;
    logic [7:0] exp_frame [19];
    randomize_inputs();
    pix[3] = 16'h1111;
    for (int i = 0; i < 19; i++) exp_frame[i] = exp_byte(i, ptat, pix);
    open_read(aw, ac, ar);
    for (int i = 0; i < 19; i++) begin
      if (i == 5) pix[3] = 16'h2222;
      read_byte(i != 18, rx_data[i]);
    end
    i2c_stop();
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (rx_data[i] !== exp_frame[i]) begin errors++; $display("[TB] FAIL snap_byte%0d: got %h expected %h", i, rx_data[i], exp_frame[i]); end
    end
  endtask

  task automatic test_rejects();
    logic a;
    int low0;
    low0 = low_cnt;
    i2c_start();
    write_byte(8'h16, a);
    i2c_stop();
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL rej_addr_ack: got %b expected 0", a); end
    checks++; if (low_cnt != low0) begin errors++; $display("[TB] FAIL rej_addr_sda: got %0d low cycles expected 0", low_cnt - low0); end
    i2c_start();
    write_byte(8'h14, a);
    checks++; if (a !== 1'b1) begin errors++; $display("[TB] FAIL rej_cmd_addr_ack: got %b expected 1", a); end
    write_byte(8'h4D, a);
    i2c_stop();
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL rej_cmd_ack: got %b expected 0", a); end
    i2c_start();
    write_byte(8'h14, a);
    write_byte(8'h4C, a);
    i2c_stop();
    i2c_start();
    write_byte(8'h15, a);
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL rej_read_after_stop: got %b expected 0", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rej_ignore_busy: got %b expected 1", busy); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rej_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overrun();
    logic aw, ac, ar;
    logic [7:0] b19, e;
    int fs0, low0;
    randomize_inputs();
    fs0 = fs_cnt;
    open_read(aw, ac, ar);
    for (int i = 0; i < 19; i++) read_byte(1'b1, rx_data[i]);
    low0 = low_cnt;
    read_byte(1'b0, b19);
    i2c_stop();
    e = exp_byte(18, ptat, pix);
    checks++; if (rx_data[18] !== e) begin errors++; $display("[TB] FAIL over_pec: got %h expected %h", rx_data[18], e); end
    checks++; if (b19 !== 8'hFF) begin errors++; $display("[TB] FAIL over_byte19: got %h expected ff", b19); end
    checks++; if (low_cnt != low0) begin errors++; $display("[TB] FAIL over_sda: got %0d low cycles expected 0", low_cnt - low0); end
    checks++; if (fs_cnt - fs0 != 1) begin errors++; $display("[TB] FAIL over_frame_sent: got %0d pulses expected 1", fs_cnt - fs0); end
  endtask

  task automatic test_early_nack();
    logic aw, ac, ar;
    logic [7:0] extra, e;
    int fs0, low0;
    randomize_inputs();
    fs0 = fs_cnt;
    open_read(aw, ac, ar);
    read_frame(5);
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL nack_sda_released: got %b expected 1", sda); end
    e = exp_byte(4, ptat, pix);
    checks++; if (rx_data[4] !== e) begin errors++; $display("[TB] FAIL nack_byte4: got %h expected %h", rx_data[4], e); end
    low0 = low_cnt;
    read_byte(1'b0, extra);
    i2c_stop();
    checks++; if (extra !== 8'hFF || low_cnt != low0) begin errors++; $display("[TB] FAIL nack_after: got %h/%0d expected ff/0", extra, low_cnt - low0); end
    checks++; if (fs_cnt != fs0) begin errors++; $display("[TB] FAIL nack_frame_sent: got %0d pulses expected 0", fs_cnt - fs0); end
  endtask

  task automatic test_reset_midframe();
    logic aw, ac, ar;
    logic [7:0] e;
    int fs0;
    randomize_inputs();
    pix[2] = 16'h0000;
    open_read(aw, ac, ar);
    for (int i = 0; i < 7; i++) read_byte(1'b1, rx_data[i]);
    m_sda = 1'b1;
    #1;
    checks++; if (sda !== 1'b0) begin errors++; $display("[TB] FAIL mid_driving_zero: got %b expected 0", sda); end
    rst = 1'b0;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_sda: got %b expected released", sda); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
    #(2 * Q) rst = 1'b1;
    #Q;
    i2c_stop();
    randomize_inputs();
    fs0 = fs_cnt;
    open_read(aw, ac, ar);
    read_frame(19);
    i2c_stop();
    checks++; if ({aw, ac, ar} !== 3'b111) begin errors++; $display("[TB] FAIL mid_after_acks: got %b expected 111", {aw, ac, ar}); end
    for (int i = 0; i < 19; i++) begin
      e = exp_byte(i, ptat, pix);
      checks++;
      if (rx_data[i] !== e) begin errors++; $display("[TB] FAIL mid_after_byte%0d: got %h expected %h", i, rx_data[i], e); end
    end
    checks++; if (fs_cnt - fs0 != 1) begin errors++; $display("[TB] FAIL mid_after_frame_sent: got %0d pulses expected 1", fs_cnt - fs0); end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_ordering();
    test_random_frames();
    test_snapshot();
    test_rejects();
    test_overrun();
    test_early_nack();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_thermo_responder.md
Name: i2c_thermo_responder

Overview:
- I2C target (responder) emulating the 8-pixel IR thermopile sensor that our i2c master polls.
- Answers the sensor's command/read sequence with a PTAT word, eight 16-bit pixel words and a PEC byte.
- Used for bench and hardware-in-loop testing of the temperature path and the memory-mapped temperature registers, without the physical sensor.
- Pixel and PTAT values come from core-side inputs; the values are snapshotted per read frame.

Parameters:
- I2C_ADDR, 7'h0A, 7-bit target address.
- CMD_BYTE, 8'h4C, the only accepted command byte.
- SYNC_STAGES, 2, synchroniser depth on SCL and SDA inputs (minimum 2).

Ports:
- ref_clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- SCL  input  1  I2C clock from the master (the responder never stretches the clock).
- SDA  inout  1  I2C data, open-drain: the block drives 1'b0 or 1'bz only.
- ptat  input  16  reference temperature word.
- pix_0 .. pix_7  input  16 each  pixel temperature words.
- busy  output  1  high whenever the state is not IDLE.
- frame_sent  output  1  one-cycle pulse when the master finishes clocking out byte 18 (the PEC byte).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, SDA=z, busy=0, frame_sent=0, cmd_valid=0.
  - Byte index, shift register and CRC are cleared.
- Input sampling:
  - SCL and SDA pass through SYNC_STAGES flops, then a 1-cycle edge detector.
  - All decisions use the synchronised signals.
- Bus condition detection:
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
  - START in any state goes to ADDR, bit count 0. This is how a repeated start is handled.
  - STOP in any state goes to IDLE, releases SDA and clears cmd_valid.
- Bit timing:
  - Incoming bits are sampled on the SCL rising edge.
  - The responder changes SDA only in the ref_clk cycle after an SCL falling edge is detected.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift in 8 bits, MSB first, on SCL rising edges.
    - After the 8th bit, if addr[7:1]==I2C_ADDR: write (bit0=0) goes to ADDR_ACK_W.
    - Read (bit0=1) goes to ADDR_ACK_R only if cmd_valid=1.
    - Anything else (mismatch, or a read without cmd_valid) goes to IGNORE with no ACK.
  - ADDR_ACK_W / ADDR_ACK_R: drive SDA low from the SCL fall after bit 8 until the next SCL fall.
    - ADDR_ACK_R also snapshots ptat and pix_0..7 into a 144-bit frame register, resets the byte index to 0 and sets CRC=8'h00.
    - ADDR_ACK_W then goes to CMD. ADDR_ACK_R then goes to TX_BYTE with byte 0 loaded.
  - CMD: shift in 8 bits.
    - If the byte equals CMD_BYTE: ACK, set cmd_valid=1, go to CMD_DONE.
    - Otherwise: no ACK, go to IGNORE.
  - CMD_DONE: any further written byte is NACKed and the state goes to IGNORE. START and STOP are handled as above.
  - TX_BYTE: drive the MSB of the current byte after the SCL fall, one bit per SCL fall. A 1 bit releases SDA; a 0 bit drives it low. After 8 bits, release SDA and go to TX_ACK.
  - TX_ACK: sample the master's ACK on the SCL rise.
    - ACK (SDA=0): increment the byte index, load the next byte, go to TX_BYTE.
    - NACK: go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Frame byte order, 19 bytes:
  - Index 0: ptat[7:0]. Index 1: ptat[15:8].
  - Index 2k+2 and 2k+3: pix_k[7:0] then pix_k[15:8], for k=0..7.
  - Index 18: PEC.
  - Index 19 and beyond (master keeps ACKing): 8'hFF, with SDA released.
- PEC:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB first, no reflection, no final XOR.
  - Computed over bytes 0..17 only. Each byte is folded into the CRC when it is loaded into the shift register.
- frame_sent pulses once, in the cycle after the SCL rise of the ACK/NACK bit following byte 18. It pulses whether the master ACKs or NACKs.
- Snapshot coherence: changes to ptat/pix_* during a frame do not affect that frame's bytes or PEC.
- cmd_valid survives a repeated START but is cleared by STOP. A read started after a STOP without a new command is NACKed.

Test Plan:
- Zero frame: ptat=0, all pix=0; master writes 0x14, 0x4C, Sr, 0x15, reads 19 bytes (ACK 18, NACK last) -> all 19 bytes 8'h00, both address ACKs and the command ACK present, frame_sent pulses once, busy=0 after STOP.
- Ordering: ptat=16'h0123, pix_0=16'h0A0B, pix_7=16'hBEEF -> bytes 0,1=23,01; 2,3=0B,0A; 16,17=EF,BE; byte 18 matches the bench CRC-8 model.
- Snapshot: change pix_3 from 16'h1111 to 16'h2222 during byte 5 -> bytes 8,9 read 11,11, and the PEC matches the 16'h1111 data.
- Rejects: write address 0x16 -> no ACK, SDA never driven. Command 0x4D -> NACK. Read 0x15 after a STOP with no command -> NACK, state stays IGNORE.
- Overrun/early NACK: master ACKs byte 18 and reads byte 19 -> 8'hFF, SDA never driven low. Master NACKs byte 4 -> SDA released and no frame_sent pulse.
- Reset mid-frame: assert rst during byte 7 while driving a 0 bit -> SDA=z immediately, busy=0; the next full transaction completes correctly.
